// File: rtl/matmul_result_drain.sv
// -----------------------------------------------------------------------------
// matmul_result_drain
//
// Purpose:
//   Consumer-side partner of the NxN matrix multiply array. The whole result
//   tile is captured in one cycle into a two-slot ping-pong buffer. Tiles are
//   then streamed out one row per beat over a valid/ready interface, row 0
//   first. The array can deliver the next tile while the current one drains.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   tile_valid  in   results holds a finished tile this cycle
//   tile_ready  out  a buffer slot is free; capture on tile_valid && tile_ready
//   results     in   [row][col] tile of DATA_W-bit signed elements
//   out_valid   out  out_data holds a valid row beat
//   out_ready   in   downstream accepts the beat on out_valid && out_ready
//   out_data    out  [col] elements of the current row (0 while idle)
//   out_row     out  row index of the current beat
//   out_last    out  high on the beat carrying row N-1
//   drop_err    out  sticky: a tile was offered while both slots were full
//
// Build option:
//   DRAIN_SAT16_EN - when defined, each element is arithmetically shifted
//   right by SHIFT and saturated to the signed 16-bit range at capture time.
//   When undefined, elements pass through untouched and SHIFT has no effect.
// -----------------------------------------------------------------------------
module matmul_result_drain #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    tile_valid,
  output logic                                    tile_ready,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]         results,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N-1:0][DATA_W-1:0]                out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]    out_row,
  output logic                                    out_last,
  output logic                                    drop_err
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // A shift of DATA_W or more would leave nothing of the element.
  if (SHIFT < 0 || SHIFT >= DATA_W) begin : g_shift_range_check
    $error("matmul_result_drain: SHIFT must be in [0, DATA_W-1]");
  end

  // ---------------------------------------------------------------------------
  // Capture-path element conditioning
  // ---------------------------------------------------------------------------
  logic [N-1:0][N-1:0][DATA_W-1:0] capture_data;

`ifdef DRAIN_SAT16_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(32767);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-32768);
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
`ifdef DRAIN_SAT16_EN
      logic signed [DATA_W-1:0] shifted;
      assign shifted = $signed(results[gi][gj]) >>> SHIFT;
      assign capture_data[gi][gj] = (shifted > SAT_MAX) ? SAT_MAX :
                                    (shifted < SAT_MIN) ? SAT_MIN : shifted;
`else
      assign capture_data[gi][gj] = results[gi][gj];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong tile storage (contents need no reset; occupancy qualifies them)
  // ---------------------------------------------------------------------------
  logic [N-1:0][N-1:0][DATA_W-1:0] tile_buf_q [2];

  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic [ROW_W-1:0] row_q;
  state_t           state_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             drop_err_q;
  logic             capture;
  logic             pop;

  // Depends on registered occupancy only, never on tile_valid.
  assign tile_ready = (occ_q < 2'd2);
  assign capture    = tile_valid && tile_ready;
  // A tile leaves the buffer when its last row is handshaken.
  assign pop        = out_valid_q && out_ready && (row_q == LAST_ROW);

  always_comb begin
    occ_d = occ_q;
    if (capture && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      tile_buf_q[wr_ptr_q] <= capture_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain state machine with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (capture) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (tile_valid && !tile_ready) begin
        drop_err_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          // Waiting one cycle after occupancy rises keeps tile_ready and the
          // start decision free of any combinational path from tile_valid.
          if (occ_q != 2'd0) begin
            state_q     <= ST_DRAIN;
            out_valid_q <= 1'b1;
            row_q       <= '0;
            out_last_q  <= (N == 1);
          end
        end

        ST_DRAIN: begin
          if (out_ready) begin
            if (row_q == LAST_ROW) begin
              row_q    <= '0;
              rd_ptr_q <= ~rd_ptr_q;
              // Looking at the post-update occupancy lets a tile captured in
              // this very cycle follow without a bubble beat.
              if (occ_d != 2'd0) begin
                out_last_q <= (N == 1);
              end else begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
            end else begin
              row_q      <= row_q + 1'b1;
              out_last_q <= ((row_q + 1'b1) == LAST_ROW);
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = out_valid_q;
  assign out_row   = row_q;
  assign out_last  = out_last_q;
  assign drop_err  = drop_err_q;
  // Row read is a pure mux of registered state, so it holds during stalls.
  assign out_data  = out_valid_q ? tile_buf_q[rd_ptr_q][row_q] : '0;

endmodule

// File: tb/tb_matmul_result_drain.sv
module tb_matmul_result_drain;

  localparam int N      = 4;
  localparam int DATA_W = 32;

  logic                            clk = 1'b0;
  logic                            reset;
  logic                            tile_valid;
  logic                            tile_ready;
  logic [N-1:0][N-1:0][DATA_W-1:0] results;
  logic                            out_valid;
  logic                            out_ready;
  logic [N-1:0][DATA_W-1:0]        out_data;
  logic [1:0]                      out_row;
  logic                            out_last;
  logic                            drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matmul_result_drain #(.N(N), .DATA_W(DATA_W), .SHIFT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .results    (results),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_last   (out_last),
    .drop_err   (drop_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Element value expected on the output for a stored input element.
  function automatic logic [31:0] exp_elem(input logic [31:0] x);
`ifdef DRAIN_SAT16_EN
    logic signed [31:0] e;
    e = $signed(x) >>> 8;
    if (e > 32767) e = 32767;
    else if (e < -32768) e = -32768;
    return e;
`else
    return x;
`endif
  endfunction

  function automatic logic [N-1:0][N-1:0][DATA_W-1:0] make_tile(input logic [31:0] base);
    logic [N-1:0][N-1:0][DATA_W-1:0] t;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        t[r][c] = base + 32'(16 * r + c);
    return t;
  endfunction

  function automatic logic [N-1:0][DATA_W-1:0] exp_row(input logic [31:0] base, input int r);
    logic [N-1:0][DATA_W-1:0] row;
    for (int c = 0; c < N; c++)
      row[c] = exp_elem(base + 32'(16 * r + c));
    return row;
  endfunction

  // Runs at negedges: checks every presented beat against the expected
  // tile/row sequence, drives out_ready from rdy_pat once beats start.
  task automatic drain_check(input string tag, input int ntiles, input logic [31:0] b0,
                             input logic [31:0] b1, input logic [3:0] rdy_pat);
    int row_e = 0;
    int tile_e = 0;
    int beats = 0;
    int idx = 0;
    int cyc = 0;
    bit started = 0;
    bit hs;
    logic [31:0] base;
    while (beats < ntiles * N && cyc < 100) begin
      base = (tile_e == 0) ? b0 : b1;
      if (out_valid) begin
        started = 1;
        check({tag, " row"}, 128'(out_row), 128'(row_e));
        check({tag, " data"}, 128'(out_data), 128'(exp_row(base, row_e)));
        check({tag, " last"}, 128'(out_last), 128'(row_e == N - 1));
        out_ready = rdy_pat[idx % 4];
        idx++;
      end else begin
        if (started) check({tag, " bubble"}, 128'(out_valid), 128'(1));
        out_ready = 1'b1;
      end
      hs = out_valid && out_ready;
      @(negedge clk);
      cyc++;
      if (hs) begin
        beats++;
        if (row_e == N - 1) begin
          row_e = 0;
          tile_e++;
        end else begin
          row_e++;
        end
      end
    end
    check({tag, " beats"}, 128'(beats), 128'(ntiles * N));
    check({tag, " idle after"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [N-1:0][N-1:0][DATA_W-1:0] t6;
    logic [N-1:0][DATA_W-1:0]        r6;

    reset      = 1'b1;
    tile_valid = 1'b0;
    out_ready  = 1'b0;
    results    = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset tile_ready", 128'(tile_ready), 128'(1));
    check("reset drop_err", 128'(drop_err), 128'(0));
    check("reset out_row", 128'(out_row), 128'(0));
    check("reset out_last", 128'(out_last), 128'(0));
    check("reset out_data", 128'(out_data), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Test 1: single tile, out_ready held high.
    results = make_tile(32'h0); tile_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    check("t1 latency idle", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("t1 first beat valid", 128'(out_valid), 128'(1));
    drain_check("t1", 1, 32'h0, 32'h0, 4'b1111);

    // Test 2: out_ready toggles 1,0,0,1 during drain.
    results = make_tile(32'h100); tile_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    tile_valid = 1'b0;
    drain_check("t2", 1, 32'h100, 32'h0, 4'b1001);

    // Test 3: three back-to-back tiles while stalled; third must be dropped.
    out_ready = 1'b0;
    results = make_tile(32'h200); tile_valid = 1'b1;
    @(negedge clk);
    check("t3 ready after 1st", 128'(tile_ready), 128'(1));
    results = make_tile(32'h300);
    @(negedge clk);
    check("t3 full ready", 128'(tile_ready), 128'(0));
    check("t3 no drop yet", 128'(drop_err), 128'(0));
    results = make_tile(32'h400);
    @(negedge clk);
    tile_valid = 1'b0;
    check("t3 drop_err set", 128'(drop_err), 128'(1));
    check("t3 still full", 128'(tile_ready), 128'(0));
    drain_check("t3", 2, 32'h200, 32'h300, 4'b1111);
    check("t3 ready after drain", 128'(tile_ready), 128'(1));

    // Test 4: capture on the same cycle as the row-3 handshake.
    results = make_tile(32'h500); tile_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    k = 0;
    while (!(out_valid && out_row == 2'd3) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t4 at row3", 128'(out_row), 128'(3));
    check("t4 row3 data", 128'(out_data), 128'(exp_row(32'h500, 3)));
    check("t4 ready at row3", 128'(tile_ready), 128'(1));
    results = make_tile(32'h600); tile_valid = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    check("t4 occupancy stays 1", 128'(tile_ready), 128'(1));
    check("t4 next valid", 128'(out_valid), 128'(1));
    drain_check("t4", 1, 32'h600, 32'h0, 4'b1111);

    // Test 5: reset mid-drain with both slots full.
    out_ready = 1'b0;
    results = make_tile(32'h700); tile_valid = 1'b1;
    @(negedge clk);
    results = make_tile(32'h800);
    @(negedge clk);
    tile_valid = 1'b0;
    check("t5 full", 128'(tile_ready), 128'(0));
    check("t5 row0 valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5 row2 shown", 128'(out_row), 128'(2));
    check("t5 drop_err sticky", 128'(drop_err), 128'(1));
    reset = 1'b1;
    @(negedge clk);
    check("t5 reset out_valid", 128'(out_valid), 128'(0));
    check("t5 reset tile_ready", 128'(tile_ready), 128'(1));
    check("t5 reset drop_err", 128'(drop_err), 128'(0));
    check("t5 reset out_row", 128'(out_row), 128'(0));
    check("t5 reset out_data", 128'(out_data), 128'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5 tiles discarded", 128'(out_valid), 128'(0));
    results = make_tile(32'h900); tile_valid = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    drain_check("t5 new tile", 1, 32'h900, 32'h0, 4'b1111);

    // Test 6: shift/saturation corner values (raw copy in the default build).
    t6 = '0;
    t6[0][0] = 32'h7FFFFFFF;
    t6[0][1] = 32'hC0000000;
    t6[0][2] = 32'h00012345;
    t6[0][3] = 32'hFFFFFF00;
`ifdef DRAIN_SAT16_EN
    r6 = {32'hFFFFFFFF, 32'h00000123, 32'hFFFF8000, 32'h00007FFF};
`else
    r6 = {32'hFFFFFF00, 32'h00012345, 32'hC0000000, 32'h7FFFFFFF};
`endif
    out_ready = 1'b0;
    results = t6; tile_valid = 1'b1;
    @(negedge clk);
    tile_valid = 1'b0;
    @(negedge clk);
    check("t6 valid", 128'(out_valid), 128'(1));
    check("t6 row", 128'(out_row), 128'(0));
    check("t6 data", 128'(out_data), 128'(r6));
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t6 idle after", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
